iob_eth_dma_buf: RTL

Write-posting buffer between the Ethernet MAC's DMA master port (IOb side, after Wishbone-to-IOb conversion) and system memory. DMA writes (RX descriptor/frame data) are accepted immediately into a small FIFO and drained to memory in order. Reads (TX data/descriptor fetch) are held until every posted write has completed, which preserves write-before-read ordering. IOb slave on the MAC side, IOb master on the memory side.

---
 rtl/iob_eth_dma_buf_if.sv | 18 +
 rtl/iob_eth_dma_buf.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/iob_eth_dma_buf_if.sv
// IOb request/response bundle: the master drives the request fields, the slave
// answers with ready and read data.
interface iob_eth_dma_buf_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_eth_dma_buf.sv
// Write-posting buffer between the Ethernet DMA port and memory: writes are
// queued and drained in order, reads wait until every posted write has completed.
module iob_eth_dma_buf #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  iob_eth_dma_buf_if.slave      s_if,
  iob_eth_dma_buf_if.master     m_if,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  idle
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 32'd1 << DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_RSP  = 2'd3
  } state_t;

  state_t            state_q,   state_d;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic [PTR_W-1:0]  level_q,   level_d;
  logic              m_valid_q, m_valid_d;
  logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0] m_wstrb_q, m_wstrb_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              idle_q,    idle_d;

  logic              is_write_c;
  logic              full_c;
  logic              port_free_c;
  logic              push_c;
  logic              pop_c;
  logic              s_ready_c;
  entry_t            head_c;

  // Next-state: FIFO push/pop, memory-port loading and the read sequencer.
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    rdata_d   = rdata_q;

    is_write_c  = s_if.valid && (s_if.wstrb != '0);
    full_c      = (level_q == PTR_W'(DEPTH));
    port_free_c = !m_valid_q || m_if.ready;
    // No acceptance while reset is asserted: the entry would be dropped anyway.
    push_c      = rst && is_write_c && !full_c && (state_q == ST_IDLE);
    pop_c       = port_free_c && (level_q != '0);
    s_ready_c   = push_c || (rst && (state_q == ST_RD_RSP));
    head_c      = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    if (m_valid_q && m_if.ready) begin
      m_valid_d = 1'b0;
    end

    if (push_c) begin
      mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = '{addr: s_if.addr, wdata: s_if.wdata, wstrb: s_if.wstrb};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop_c) begin
      m_valid_d = 1'b1;
      m_addr_d  = head_c.addr;
      m_wdata_d = head_c.wdata;
      m_wstrb_d = head_c.wstrb;
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
    end

    level_d = level_q + PTR_W'(push_c) - PTR_W'(pop_c);

    // Pop and read issue are exclusive: a read is only issued once the FIFO is empty.
    case (state_q)
      ST_IDLE: begin
        if (s_if.valid && (s_if.wstrb == '0)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((level_q == '0) && port_free_c) begin
          m_valid_d = 1'b1;
          m_addr_d  = s_if.addr;
          m_wdata_d = '0;
          m_wstrb_d = '0;
          state_d   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (m_valid_q && m_if.ready) begin
          rdata_d = m_if.rdata;
          state_d = ST_RD_RSP;
        end
      end
      ST_RD_RSP: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    idle_d = (level_d == '0) && !m_valid_d && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      rdata_q   <= '0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      rdata_q   <= rdata_d;
      idle_q    <= idle_d;
    end
  end

  assign s_if.ready = s_ready_c;
  assign s_if.rdata = rdata_q;
  assign m_if.valid = m_valid_q;
  assign m_if.addr  = m_addr_q;
  assign m_if.wdata = m_wdata_q;
  assign m_if.wstrb = m_wstrb_q;
  assign level      = level_q;
  assign idle       = idle_q;

endmodule
